// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared widths, state encodings and alignment mask for the LSU
package load_store_unit_pkg;

  localparam int LSU_DATA_W = 16;
  localparam int LSU_ADDR_W = 9;

  // 16-bit words on a byte-addressed bus: bit 0 set means misaligned
  localparam int LSU_ALIGN_MASK = 1;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator in front of data_memory
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W      = LSU_DATA_W,
  parameter int ADDR_W      = LSU_ADDR_W,
  parameter int RD_LAT      = 0,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // mem_read stays up for RD_LAT+1 cycles; the counter runs 0..RD_LAT
  localparam logic [3:0] LAT_LAST = 4'(RD_LAT);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [3:0]        r_lat_cnt;
  logic [3:0]        w_lat_cnt_nxt;
  logic              r_mem_read;
  logic              w_mem_read_nxt;
  logic              r_mem_write;
  logic              w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              r_rsp_valid;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              r_rsp_err;
  logic              w_rsp_err_nxt;
  logic              w_misaligned;

  assign w_misaligned = (ALIGN_CHECK != 0) &&
                        ((req_addr & ADDR_W'(LSU_ALIGN_MASK)) != '0);

  // State register plus every registered output; async reset drops any in-flight strobe at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LSU_IDLE;
      r_lat_cnt   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next state and next register values; strobes default low so each is a deliberate pulse
  always_comb begin
    w_state_nxt     = r_state;
    w_lat_cnt_nxt   = r_lat_cnt;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      LSU_IDLE: begin
        if (req_valid) begin
          w_mem_addr_nxt  = req_addr;
          w_mem_wdata_nxt = req_wdata;
          if (w_misaligned) begin
            // Fault straight to the response; memory never sees this access
            w_state_nxt     = LSU_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else if (req_we) begin
            w_state_nxt     = LSU_WRITE;
            w_mem_write_nxt = 1'b1;
          end else begin
            w_state_nxt    = LSU_READ;
            w_mem_read_nxt = 1'b1;
            w_lat_cnt_nxt  = '0;
          end
        end
      end

      LSU_WRITE: begin
        w_state_nxt     = LSU_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
      end

      LSU_READ: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt     = LSU_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = mem_rdata;
        end else begin
          w_mem_read_nxt = 1'b1;
          w_lat_cnt_nxt  = r_lat_cnt + 4'd1;
        end
      end

      LSU_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = LSU_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
        end
      end

      default: w_state_nxt = LSU_IDLE;
    endcase
  end

  assign req_ready = (r_state == LSU_IDLE);
  assign busy      = (r_state != LSU_IDLE);
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit (RD_LAT 0 and 1)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rv0, rr0, sv0, se0, mr0, mw0, b0;
  logic        rv1, rr1, sv1, se1, mr1, mw1, b1;
  logic [15:0] sd0, wd0, md0, sd1, wd1, md1q;
  logic [8:0]  ma0, ma1;

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  always #5 clk = ~clk;

  assign rv0 = req_valid & ~sel;
  assign rv1 = req_valid & sel;

  load_store_unit #(.DATA_W(16), .ADDR_W(9), .RD_LAT(0), .ALIGN_CHECK(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(sv0), .rsp_ready(rsp_ready),
    .rsp_rdata(sd0), .rsp_err(se0), .mem_read(mr0), .mem_write(mw0), .mem_addr(ma0),
    .mem_wdata(wd0), .mem_rdata(md0), .busy(b0));

  load_store_unit #(.DATA_W(16), .ADDR_W(9), .RD_LAT(1), .ALIGN_CHECK(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(sv1), .rsp_ready(rsp_ready),
    .rsp_rdata(sd1), .rsp_err(se1), .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1),
    .mem_wdata(wd1), .mem_rdata(md1q), .busy(b1));

  // Word-indexed memories: combinational read for dut0, registered read for dut1
  assign md0 = mem0[ma0[8:1]];
  always @(posedge clk) begin
    if (mw0) mem0[ma0[8:1]] <= wd0;
    if (mw1) mem1[ma1[8:1]] <= wd1;
    if (mr1) md1q <= mem1[ma1[8:1]];
  end

  wire        o_req_ready = sel ? rr1 : rr0;
  wire        o_rsp_valid = sel ? sv1 : sv0;
  wire [15:0] o_rsp_rdata = sel ? sd1 : sd0;
  wire        o_rsp_err   = sel ? se1 : se0;
  wire        o_mem_read  = sel ? mr1 : mr0;
  wire        o_mem_write = sel ? mw1 : mw0;
  wire        o_busy      = sel ? b1 : b0;
  wire [8:0]  o_mem_addr  = sel ? ma1 : ma0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          hold;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic we, input logic [8:0] a,
                              input logic [15:0] d, input int h, input logic [15:0] er,
                              input logic ee, input int el, input int erd, input int ewr);
    vec_t v;
    v.sel = s; v.we = we; v.addr = a; v.wdata = d; v.hold = h;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  task automatic do_vec(input vec_t v);
    int lat, nrd, nwr, both;
    logic [15:0] d0;
    logic e0;
    sel = v.sel;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b0;
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; both = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (o_mem_read) nrd++;
      if (o_mem_write) nwr++;
      if (o_mem_read && o_mem_write) both++;
      if (o_rsp_valid) lat = i;
    end
    if (lat == 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_rdata", 32'(o_rsp_rdata), 32'(v.exp_rdata));
    chk("rsp_err", 32'(o_rsp_err), 32'(v.exp_err));
    chk("mem_read_cycles", 32'(nrd), 32'(v.exp_rd));
    chk("mem_write_cycles", 32'(nwr), 32'(v.exp_wr));
    chk("read_write_overlap", 32'(both), 32'd0);
    d0 = o_rsp_rdata;
    e0 = o_rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_rdata", 32'(o_rsp_rdata), 32'(d0));
      chk("hold_err", 32'(o_rsp_err), 32'(e0));
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
      chk("hold_busy", 32'(o_busy), 32'd1);
      chk("hold_strobes", 32'({o_mem_read, o_mem_write}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("after_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("after_req_ready", 32'(o_req_ready), 32'd1);
    chk("after_busy", 32'(o_busy), 32'd0);
  endtask

  vec_t vecs [15];

  logic        bb_we   [4];
  logic [8:0]  bb_addr [4];
  logic [15:0] bb_wd   [4];
  logic [15:0] bb_exp  [4];

  initial begin
    int acc, rsps, both, bad;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    //            sel  we    addr    wdata     hold rdata    err lat rd wr
    vecs[0]  = mk(0, 1, 9'h002, 16'hABCD, 0, 16'h0000, 0, 2, 0, 1);
    vecs[1]  = mk(0, 0, 9'h002, 16'h0000, 1, 16'hABCD, 0, 2, 1, 0);
    vecs[2]  = mk(0, 1, 9'h004, 16'h1234, 0, 16'h0000, 0, 2, 0, 1);
    vecs[3]  = mk(0, 1, 9'h006, 16'h5678, 0, 16'h0000, 0, 2, 0, 1);
    vecs[4]  = mk(0, 0, 9'h004, 16'h0000, 3, 16'h1234, 0, 2, 1, 0);
    vecs[5]  = mk(0, 0, 9'h006, 16'h0000, 3, 16'h5678, 0, 2, 1, 0);
    vecs[6]  = mk(0, 0, 9'h005, 16'h0000, 0, 16'h0000, 1, 1, 0, 0);
    vecs[7]  = mk(0, 1, 9'h005, 16'hFFFF, 2, 16'h0000, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0, 9'h004, 16'h0000, 0, 16'h1234, 0, 2, 1, 0);
    vecs[9]  = mk(0, 0, 9'h008, 16'h0000, 0, 16'h0000, 0, 2, 1, 0);
    vecs[10] = mk(1, 1, 9'h004, 16'h1234, 0, 16'h0000, 0, 2, 0, 1);
    vecs[11] = mk(1, 0, 9'h004, 16'h0000, 2, 16'h1234, 0, 3, 2, 0);
    vecs[12] = mk(1, 0, 9'h003, 16'h0000, 0, 16'h0000, 1, 1, 0, 0);
    vecs[13] = mk(1, 1, 9'h1FE, 16'hBEEF, 0, 16'h0000, 0, 2, 0, 1);
    vecs[14] = mk(1, 0, 9'h1FE, 16'h0000, 1, 16'hBEEF, 0, 3, 2, 0);

    bb_we[0] = 1; bb_addr[0] = 9'h010; bb_wd[0] = 16'h1111; bb_exp[0] = 16'h0000;
    bb_we[1] = 1; bb_addr[1] = 9'h012; bb_wd[1] = 16'h2222; bb_exp[1] = 16'h0000;
    bb_we[2] = 0; bb_addr[2] = 9'h010; bb_wd[2] = 16'h0000; bb_exp[2] = 16'h1111;
    bb_we[3] = 0; bb_addr[3] = 9'h012; bb_wd[3] = 16'h0000; bb_exp[3] = 16'h2222;

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("reset_req_ready", 32'(rr0), 32'd1);
    chk("reset_rsp_valid", 32'(sv0), 32'd0);
    chk("reset_strobes", 32'({mr0, mw0, mr1, mw1}), 32'd0);
    chk("reset_busy", 32'({b0, b1}), 32'd0);
    chk("reset_mem_addr", 32'(ma0), 32'd0);
    chk("reset_rsp_rdata", 32'(sd0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset raised during the mem_write cycle must drop the write immediately
    sel = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h008; req_wdata = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midwrite_strobe_up", 32'(mw0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midwrite_strobe_down", 32'(mw0), 32'd0);
    chk("midwrite_rsp_valid", 32'(sv0), 32'd0);
    chk("midwrite_busy", 32'(b0), 32'd0);
    chk("midwrite_req_ready", 32'(rr0), 32'd1);
    chk("midwrite_mem_addr", 32'(ma0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) do_vec(vecs[i]);

    // Back-to-back with req_valid and rsp_ready held high
    sel = 1'b0;
    @(negedge clk);
    acc = 0; rsps = 0; both = 0; bad = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && rsps < 4; c++) begin
      if (acc < 4) begin
        req_valid = 1'b1; req_we = bb_we[acc]; req_addr = bb_addr[acc]; req_wdata = bb_wd[acc];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (o_mem_read && o_mem_write) both++;
      if (o_busy == o_req_ready) bad++;
      if (o_rsp_valid) begin
        chk("b2b_rdata", 32'(o_rsp_rdata), 32'(bb_exp[rsps]));
        chk("b2b_err", 32'(o_rsp_err), 32'd0);
        rsps++;
      end
      if (req_valid && o_req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_responses", 32'(rsps), 32'd4);
    chk("b2b_overlap", 32'(both), 32'd0);
    chk("b2b_busy_vs_ready", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts single load/store requests from the core over a valid/ready handshake.
- Drives mem_read/mem_write/mem_addr/mem_wdata into data_memory and captures mem_rdata.
- Returns one response per request over a valid/ready handshake.
- Sits between the execute/memory pipeline stage and data_memory.
- Checks word alignment (16-bit words, byte addresses) and faults misaligned accesses without touching memory.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, byte address width (matches data_memory addr).
- RD_LAT, 0, memory read latency in cycles (0 = combinational read, 1 = registered read); mem_read is held RD_LAT+1 cycles.
- ALIGN_CHECK, 1, 1 = fault when addr[0]=1; 0 = pass misaligned addresses through unchanged.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_W  load data (0 for stores and faults).
- rsp_err  out  1  misalignment fault.
- mem_read  out  1  to data_memory.
- mem_write  out  1  to data_memory.
- mem_addr  out  ADDR_W  to data_memory.
- mem_wdata  out  DATA_W  to data_memory.
- mem_rdata  in  DATA_W  from data_memory.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE. Outputs: req_ready=1; rsp_valid, rsp_err, mem_read, mem_write, busy = 0; rsp_rdata, mem_addr, mem_wdata = 0; read-latency counter = 0. A reset mid-operation drops the in-flight request; mem_write falls immediately (async), so no partial write is issued after rst rises.
- All mem_* and rsp_* outputs are driven from registers, with no combinational path from req_* to mem_*.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid at edge T:
  - Register addr, we and wdata.
  - If ALIGN_CHECK and req_addr[0]=1: go to RESP with rsp_err=1, rsp_rdata=0; no mem strobe ever asserted.
  - Else if we: go to WRITE.
  - Else: go to READ.
- WRITE: mem_write=1 for exactly one cycle (T+1) with the registered mem_addr/mem_wdata. Go to RESP: rsp_valid at T+2, rsp_err=0, rsp_rdata=0.
- READ: mem_read=1 with mem_addr stable for RD_LAT+1 cycles. On the clock edge ending the last cycle, capture mem_rdata into rsp_rdata. Go to RESP.
  - Latency: rsp_valid at T+2+RD_LAT.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready is sampled high. Then return to IDLE: rsp_valid=0, rsp_err cleared.
  - mem_read/mem_write=0 throughout RESP.
- req_ready=0 in READ, WRITE and RESP. Requests are not accepted during RESP, even in the same cycle as rsp_ready.
- Peak throughput: one access per 3+RD_LAT cycles.
- mem_read and mem_write are never high in the same cycle. mem_addr/mem_wdata hold their last values in IDLE; only the strobes gate memory.
- rsp_ready high while rsp_valid=0: ignored.
- req_valid held high across a response: a new accept occurs only after returning to IDLE.
- Misaligned store with ALIGN_CHECK=0: issued as-is; data_memory defines the effect.

Decomposition:
- Shared defines header:
  - DATA_W/ADDR_W defaults.
  - LSU state encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3).
  - Alignment-mask constant.
- Single module; no sub-module is natural. The read-latency counter is a few lines inline.

Test Plan:
- Reset mid-WRITE: assert rst during the mem_write cycle -> mem_write=0 immediately, rsp_valid=0, busy=0, req_ready=1.
- Store 0xABCD @0x002, then load @0x002 (RD_LAT=0) -> each:
  - mem_write pulse exactly 1 cycle at T+1;
  - store response at T+2 (err=0, rdata=0);
  - load rsp_rdata=0xABCD, err=0, at T+2.
- Stores 0x1234@0x004 and 0x5678@0x006, then loads @0x004 and @0x006 with rsp_ready held low 3 cycles -> rsp_valid and data held stable; returns 0x1234 then 0x5678; req_ready=0 until the handshake.
- Load @0x005 with ALIGN_CHECK=1 -> rsp_err=1 and rsp_rdata=0 at T+1; mem_read/mem_write never asserted.
- RD_LAT=1: load @0x004 -> mem_read high for 2 cycles; rsp_rdata=0x1234 at T+3.
- Back-to-back: req_valid held high for 4 requests -> exactly 4 accepts and 4 responses; never mem_read&mem_write; busy low only in IDLE cycles.
